// File: rtl/vedic_mul8_seq_ctrl.sv
// rtl/vedic_mul8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over one shared 4x4 core
//
// Computes product = a * b (16-bit) by issuing the four nibble partial
// products to an external 4x4 multiplier core and shift-accumulating them.
//
// Parameter:
//   CORE_LAT  0 = combinational core (sample in issue cycle)
//             1 = registered core (sample one cycle after issue)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake, a/b latched on accept
//   a, b                 8-bit unsigned operands
//   out_valid/out_ready  result handshake
//   product              16-bit result, held after the handshake
//   core_a, core_b       nibbles driven to the shared core
//   core_p               core result core_a*core_b
//   busy                 controller is not idle
//
// Optional macro VEDIC_MUL8_ZERO_SKIP_EN: a zero operand skips the core
// entirely and completes one cycle after accept with product 0.

module vedic_mul8_seq_ctrl #(
  parameter int CORE_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic [3:0]  core_a,
  output logic [3:0]  core_b,
  input  logic [7:0]  core_p,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PP0, S_PP1, S_PP2, S_PP3, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        phase, phase_nxt;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc, prod_q;
  logic        accept;
  logic        sample;
  logic        zero_skip;
  logic [15:0] pp_shifted;

  assign accept    = in_valid && (state == S_IDLE);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign product   = prod_q;

`ifdef VEDIC_MUL8_ZERO_SKIP_EN
  assign zero_skip = (a == 8'h00) || (b == 8'h00);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    sample     = 1'b0;
    core_a     = 4'h0;
    core_b     = 4'h0;
    pp_shifted = 16'h0000;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = zero_skip ? S_DONE : S_PP0;
          phase_nxt = 1'b0;
        end
      end
      S_PP0: begin
        core_a = a_q[3:0];
        core_b = b_q[3:0];
      end
      S_PP1: begin
        core_a = a_q[7:4];
        core_b = b_q[3:0];
      end
      S_PP2: begin
        core_a = a_q[3:0];
        core_b = b_q[7:4];
      end
      S_PP3: begin
        core_a = a_q[7:4];
        core_b = b_q[7:4];
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Partial-product states: with a registered core the first cycle only
    // issues, the second (phase=1) samples. Operands stay constant across both.
    if (state inside {S_PP0, S_PP1, S_PP2, S_PP3}) begin
      sample = (CORE_LAT == 0) || phase;
      if (sample) begin
        phase_nxt = 1'b0;
        unique case (state)
          S_PP0:   state_nxt = S_PP1;
          S_PP1:   state_nxt = S_PP2;
          S_PP2:   state_nxt = S_PP3;
          default: state_nxt = S_DONE;
        endcase
      end else begin
        phase_nxt = 1'b1;
      end
    end

    // core_p only reaches the adder at a sample point, so an undriven core
    // elsewhere cannot contaminate the accumulator.
    if (sample) begin
      unique case (state)
        S_PP0:   pp_shifted = {8'h00, core_p};
        S_PP3:   pp_shifted = {core_p, 8'h00};
        default: pp_shifted = {4'h0, core_p, 4'h0};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      phase  <= 1'b0;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      acc    <= 16'h0000;
      prod_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        acc <= 16'h0000;
        if (zero_skip) prod_q <= 16'h0000;
      end else if (sample) begin
        acc <= acc + pp_shifted;
        // product is a separate register so it survives the next accept
        if (state == S_PP3) prod_q <= acc + pp_shifted;
      end
    end
  end

endmodule
